// File: rtl/countdown_sched_if.sv
//==============================================================================
// Module      : countdown_sched_if
// Description : Client/counter signal bundle for countdown_sched. The master
//               side drives requests, presets and the counter's done. The
//               slave side is the scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface countdown_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   preset;
    logic [NREQ-1:0]      grant;
    logic [NREQ-1:0]      ack;
    logic                 err;
    logic [15:0]          cnt_value;
    logic                 cnt_start;
    logic                 cnt_done;
    logic                 busy;

    modport master (
        output req, preset, cnt_done,
        input  grant, ack, err, cnt_value, cnt_start, busy
    );

    modport slave (
        input  req, preset, cnt_done,
        output grant, ack, err, cnt_value, cnt_start, busy
    );
endinterface

`default_nettype wire

// File: rtl/countdown_sched.sv
//==============================================================================
// Module      : countdown_sched
// Description : Round-robin sequencer that shares one two-digit ASCII
//               countdown unit among NREQ requesters. It validates the preset,
//               starts the counter, waits for done, then acks the winner.
//               Optional watchdog on cnt_done: define TIMEOUT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module countdown_sched #(
    parameter int NREQ     = 4,
    parameter int MAX_WAIT = 1024
) (
    input  wire logic        clock,
    input  wire logic        reset,
    countdown_sched_if.slave sched
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_IW-1:0]   r_ptr;
    logic [c_IW-1:0]   r_idx;
    logic [c_IW-1:0]   w_pick;
    logic              w_any;
    logic [15:0]       w_sel_preset;
    logic [15:0]       r_value;
    logic              r_err;
    logic              w_err_nxt;
    logic              w_tens_ok;
    logic              w_units_ok;
    logic              w_zero;
    logic              w_timeout;
    logic [NREQ-1:0]   w_onehot;

    // Round-robin pick: the nearest requester after the pointer wins, so the
    // farthest candidates are visited first and get overwritten by nearer ones.
    always_comb begin
        w_pick = r_ptr;
        w_any  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if ((i == ((int'(r_ptr) + k) % NREQ)) && sched.req[i]) begin
                    w_pick = c_IW'(i);
                    w_any  = 1'b1;
                end
            end
        end
    end

    // Preset of the chosen requester, captured on the IDLE latch.
    always_comb begin
        w_sel_preset = 16'h3030;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == c_IW'(i)) begin
                w_sel_preset = sched.preset[16*i +: 16];
            end
        end
    end

    // Decode the latched index into the one-hot owner vector.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_onehot[i] = (r_idx == c_IW'(i));
        end
    end

    assign w_tens_ok  = (r_value[15:8] >= 8'h30) && (r_value[15:8] <= 8'h39);
    assign w_units_ok = (r_value[7:0]  >= 8'h30) && (r_value[7:0]  <= 8'h39);
    assign w_zero     = (r_value == 16'h3030);

`ifdef TIMEOUT_EN
    localparam int c_WW = $clog2(MAX_WAIT + 1);

    logic [c_WW-1:0] r_wait_cnt;

    // Watchdog: cleared by START, counts WAIT cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_START) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_WAIT) && (32'(r_wait_cnt) < 32'(MAX_WAIT))) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Fires in the WAIT cycle that places ACK exactly MAX_WAIT clocks after START.
    assign w_timeout = (32'(r_wait_cnt) + 32'd2) >= 32'(MAX_WAIT);
`else
    // No watchdog: WAIT lasts until cnt_done (expression is constant false).
    assign w_timeout = (MAX_WAIT < 0);
`endif

    // Next-state and error decision.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!(w_tens_ok && w_units_ok)) begin
                    w_state_nxt = S_ACK;
                    w_err_nxt   = 1'b1;
                end else if (w_zero) begin
                    w_state_nxt = S_ACK;
                    w_err_nxt   = 1'b0;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // done takes precedence over a coincident timeout
                if (sched.cnt_done) begin
                    w_state_nxt = S_ACK;
                    w_err_nxt   = 1'b0;
                end else if (w_timeout) begin
                    w_state_nxt = S_ACK;
                    w_err_nxt   = 1'b1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register plus the job latch and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= c_IW'(NREQ - 1);
            r_idx   <= '0;
            r_value <= 16'h3030;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if ((r_state == S_IDLE) && w_any) begin
                r_idx   <= w_pick;
                r_value <= w_sel_preset;
            end
            if (r_state == S_ACK) begin
                r_ptr <= r_idx;
            end
        end
    end

    assign sched.busy      = (r_state != S_IDLE);
    assign sched.grant     = (r_state != S_IDLE) ? w_onehot : '0;
    assign sched.ack       = (r_state == S_ACK) ? w_onehot : '0;
    assign sched.err       = (r_state == S_ACK) && r_err;
    assign sched.cnt_start = (r_state == S_START);
    assign sched.cnt_value = r_value;

endmodule

`default_nettype wire

// File: tb/tb_countdown_sched.sv
//==============================================================================
// Module      : tb_countdown_sched
// Description : Self-checking bench for countdown_sched: directed scenarios
//               followed by randomized jobs against a job-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_countdown_sched;

    localparam int NREQ = 4;
`ifdef TIMEOUT_EN
    localparam int MAX_WAIT = 8;
`else
    localparam int MAX_WAIT = 1024;
`endif

    logic clock = 1'b0;
    logic reset;

    countdown_sched_if #(.NREQ(NREQ)) bus ();

    countdown_sched #(
        .NREQ     (NREQ),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sched (bus.slave)
    );

    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_ptr;
    logic [15:0] m_preset [NREQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_presets();
        for (int i = 0; i < NREQ; i++) bus.preset[16*i +: 16] = m_preset[i];
    endtask

    // Next requester strictly after the pointer, circularly.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic [15:0] rand_preset();
        int          r;
        logic [7:0]  t;
        logic [7:0]  u;
        logic [7:0]  edges [4];
        edges[0] = 8'h2F; edges[1] = 8'h3A; edges[2] = 8'h30; edges[3] = 8'h39;
        r = $urandom_range(0, 9);
        t = 8'h30 + 8'($urandom_range(0, 9));
        u = 8'h30 + 8'($urandom_range(0, 9));
        if (r == 0) return 16'h3030;
        if (r == 1) t = 8'($urandom_range(0, 255));
        if (r == 2) u = edges[$urandom_range(0, 3)];
        if (r == 3) t = edges[$urandom_range(0, 3)];
        return {t, u};
    endfunction

    // One complete job. Entered in an IDLE cycle with req pending; leaves in
    // the IDLE cycle that follows the ack. dly = WAIT cycles before done
    // (negative: done never comes, watchdog expected).
    task automatic run_job(input int dly, input bit noise, input bit drop_mid,
                           input bit keep_after, input bit scramble);
        int              e;
        logic [15:0]     v;
        logic [NREQ-1:0] oh;
        bit              ok;
        bit              zero;
        e = pick(bus.req, m_ptr);
        if (e < 0) e = 0;
        v    = m_preset[e];
        oh   = NREQ'(1) << e;
        ok   = is_digit(v[15:8]) && is_digit(v[7:0]);
        zero = (v == 16'h3030);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        if (noise) bus.cnt_done = 1'b1;
        step();  // CHECK
        chk("check_grant", 32'(bus.grant), 32'(oh));
        chk("check_value", 32'(bus.cnt_value), 32'(v));
        chk("check_busy", 32'(bus.busy), 32'd1);
        chk("check_start", 32'(bus.cnt_start), 32'd0);
        if (scramble) begin
            for (int i = 0; i < NREQ; i++) m_preset[i] = rand_preset();
            drive_presets();
        end
        if (!ok || zero) begin
            step();  // ACK
            bus.cnt_done = 1'b0;
            chk("fast_ack", 32'(bus.ack), 32'(oh));
            chk("fast_err", 32'(bus.err), 32'(!ok));
            chk("fast_nostart", 32'(bus.cnt_start), 32'd0);
            chk("fast_grant", 32'(bus.grant), 32'(oh));
        end else begin
            bus.cnt_done = 1'b0;
            step();  // START
            chk("start_pulse", 32'(bus.cnt_start), 32'd1);
            chk("start_grant", 32'(bus.grant), 32'(oh));
            chk("start_ack", 32'(bus.ack), 32'd0);
`ifdef TIMEOUT_EN
            if (dly < 0) begin
                for (int k = 1; k < MAX_WAIT; k++) begin
                    step();
                    chk("to_wait_ack", 32'(bus.ack), 32'd0);
                end
                step();  // ACK, MAX_WAIT clocks after START
                chk("to_ack", 32'(bus.ack), 32'(oh));
                chk("to_err", 32'(bus.err), 32'd1);
            end else
`endif
            begin
                for (int k = 0; k <= dly; k++) begin
                    step();  // WAIT
                    chk("wait_start", 32'(bus.cnt_start), 32'd0);
                    chk("wait_ack", 32'(bus.ack), 32'd0);
                    chk("wait_grant", 32'(bus.grant), 32'(oh));
                    chk("wait_value", 32'(bus.cnt_value), 32'(v));
                    if (drop_mid && k == 0) bus.req[e] = 1'b0;
                    if (k == dly) bus.cnt_done = 1'b1;
                end
                step();  // ACK
                bus.cnt_done = 1'b0;
                chk("done_ack", 32'(bus.ack), 32'(oh));
                chk("done_err", 32'(bus.err), 32'd0);
                chk("done_grant", 32'(bus.grant), 32'(oh));
            end
        end
        m_ptr = e;
        if (!keep_after) bus.req[e] = 1'b0;
        step();  // IDLE
        chk("end_busy", 32'(bus.busy), 32'd0);
        chk("end_grant", 32'(bus.grant), 32'd0);
        chk("end_ack", 32'(bus.ack), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.req      = '0;
        bus.cnt_done = 1'b0;
        for (int i = 0; i < NREQ; i++) m_preset[i] = 16'h3030;
        drive_presets();
        m_ptr = NREQ - 1;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_start", 32'(bus.cnt_start), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_value", 32'(bus.cnt_value), 32'h3030);
        repeat (2) begin
            step();
            chk("idle_noreq", 32'(bus.busy), 32'd0);
        end

        // Basic job, preset "05"
        m_preset[0] = 16'h3035; drive_presets();
        bus.req = 4'b0001;
        run_job(2, 0, 0, 0, 0);

        // Invalid tens digit, then "00"
        m_preset[0] = 16'h4135; drive_presets();
        bus.req = 4'b0001;
        run_job(0, 0, 0, 0, 0);
        m_preset[0] = 16'h3030; drive_presets();
        bus.req = 4'b0001;
        run_job(0, 0, 0, 0, 0);

        // All requesting "12", rotation over five jobs
        for (int i = 0; i < NREQ; i++) m_preset[i] = 16'h3132;
        drive_presets();
        bus.req = 4'b1111;
        for (int j = 0; j < 5; j++) run_job(2, 0, 0, 1, 0);
        bus.req = '0;
        step();
        chk("rr_idle", 32'(bus.busy), 32'd0);

        // Stray done outside WAIT, req dropped during WAIT
        m_preset[2] = 16'h3939; drive_presets();
        bus.req = 4'b0100;
        run_job(3, 1, 1, 0, 1);

        // Reset during WAIT aborts the job
        m_preset[0] = 16'h3334; drive_presets();
        bus.req = 4'b0001;
        step(); step(); step();
        chk("pre_rst_wait", 32'(bus.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_grant", 32'(bus.grant), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_ack", 32'(bus.ack), 32'd0);
        chk("arst_start", 32'(bus.cnt_start), 32'd0);
        chk("arst_value", 32'(bus.cnt_value), 32'h3030);
        m_preset[1] = 16'h3037; drive_presets();
        bus.req = 4'b0010;
        m_ptr   = NREQ - 1;
        #2 reset = 1'b0;
        run_job(1, 0, 0, 0, 0);

`ifdef TIMEOUT_EN
        m_preset[3] = 16'h3531; drive_presets();
        bus.req = 4'b1000;
        run_job(-1, 0, 0, 0, 0);
`endif

        // Randomized jobs
        for (int j = 0; j < 40; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req[i]) m_preset[i] = rand_preset();
            end
            drive_presets();
            bus.req = bus.req | NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if (bus.req == '0) bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            run_job(int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
